// File: rtl/fir_fold_sched.sv
// Sequencer for a folded TAPS-tap FIR: drives input reads, coefficient select,
// accumulator load/enable and output writes. Define FIR_SCHED_ABORT_EN to add abort_i.
module fir_fold_sched #(
  parameter int TAPS    = 5,
  parameter int N_IN    = 256,
  parameter int ADDR_W  = 8,
  parameter int SEL_W   = 3,
  parameter int MAC_LAT = 2
) (
  input  logic              clk100_i,
  input  logic              reset_i,
  input  logic              start_i,
`ifdef FIR_SCHED_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              in_rd_en_o,
  output logic [ADDR_W-1:0] in_addr_o,
  output logic [SEL_W-1:0]  coef_sel_o,
  output logic              acc_ld_o,
  output logic              acc_en_o,
  output logic              out_wr_en_o,
  output logic [ADDR_W-1:0] out_addr_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int                 L      = MAC_LAT - 1;
  localparam logic [ADDR_W-1:0]  J_LAST = ADDR_W'(N_IN - TAPS);
  localparam logic [SEL_W-1:0]   K_LAST = SEL_W'(TAPS - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  j_q, j_d;
  logic [SEL_W-1:0]   k_q, k_d;
  logic               issue;
  logic               abort_req;

  // Tag pipe: one entry per issue, aligned with the product at the accumulator.
  logic               vld_q   [MAC_LAT];
  logic               first_q [MAC_LAT];
  logic               last_q  [MAC_LAT];
  logic [ADDR_W-1:0]  tj_q    [MAC_LAT];
  logic               wr_vld_q;
  logic [ADDR_W-1:0]  wr_j_q;

`ifdef FIR_SCHED_ABORT_EN
  assign abort_req = abort_i && ((state_q == RUN) || (state_q == DRAIN));
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (k_q == K_LAST) begin
          k_d = '0;
          if (j_q == J_LAST) begin
            state_d = DRAIN;
          end else begin
            j_d = j_q + ADDR_W'(1);
          end
        end else begin
          k_d = k_q + SEL_W'(1);
        end
      end
      // The pass ends once the write of the last output has been presented.
      DRAIN: begin
        if (wr_vld_q && (wr_j_q == J_LAST)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100_i) begin
    if (!reset_i || abort_req) begin
      state_q <= IDLE;
      j_q     <= '0;
      k_q     <= '0;
      for (int i = 0; i < MAC_LAT; i++) begin
        vld_q[i]   <= 1'b0;
        first_q[i] <= 1'b0;
        last_q[i]  <= 1'b0;
        tj_q[i]    <= '0;
      end
      wr_vld_q <= 1'b0;
      wr_j_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      // Issue stage -> tag pipe entry 0
      vld_q[0]   <= issue;
      first_q[0] <= issue && (k_q == '0);
      last_q[0]  <= issue && (k_q == K_LAST);
      tj_q[0]    <= j_q;
      // Tag pipe stages 1..MAC_LAT-1
      for (int i = 1; i < MAC_LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
        tj_q[i]    <= tj_q[i-1];
      end
      // Accumulator stage -> write stage
      wr_vld_q <= vld_q[L] && last_q[L];
      wr_j_q   <= tj_q[L];
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign in_rd_en_o  = issue;
  assign in_addr_o   = issue ? (j_q + ADDR_W'(TAPS - 1) - ADDR_W'(k_q)) : '0;
  assign coef_sel_o  = issue ? k_q : '0;
  assign acc_ld_o    = vld_q[L] && first_q[L];
  assign acc_en_o    = vld_q[L] && !first_q[L];
  assign out_wr_en_o = wr_vld_q;
  assign out_addr_o  = wr_vld_q ? wr_j_q : '0;

endmodule

// File: tb/tb_fir_fold_sched.sv
// Bench for fir_fold_sched: default instance plus a TAPS=3/N_IN=8/MAC_LAT=1 instance,
// checked cycle by cycle against a closed-form schedule model.
module tb_fir_fold_sched;

  localparam int D_TAPS = 5;
  localparam int D_NIN  = 256;
  localparam int D_LAT  = 2;
  localparam int D_NI   = (D_NIN - D_TAPS + 1) * D_TAPS;
  localparam int D_DONE = D_NI + D_LAT + 1;

  logic       clk100_i = 1'b0;
  logic       reset_i  = 1'b0;
  logic       start_i  = 1'b0;
  logic       abort_i  = 1'b0;
  logic       busy_o, done_o, in_rd_en_o, acc_ld_o, acc_en_o, out_wr_en_o;
  logic [7:0] in_addr_o, out_addr_o;
  logic [2:0] coef_sel_o;

  logic       reset_s = 1'b0;
  logic       start_s = 1'b0;
  logic       abort_s = 1'b0;
  logic       busy_s, done_s, rd_s, ld_s, en_s, wr_s;
  logic [7:0] addr_s, oaddr_s;
  logic [2:0] sel_s;

  int n_checks = 0;
  int n_fail   = 0;

  fir_fold_sched dut (
    .clk100_i   (clk100_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
`ifdef FIR_SCHED_ABORT_EN
    .abort_i    (abort_i),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .in_rd_en_o (in_rd_en_o),
    .in_addr_o  (in_addr_o),
    .coef_sel_o (coef_sel_o),
    .acc_ld_o   (acc_ld_o),
    .acc_en_o   (acc_en_o),
    .out_wr_en_o(out_wr_en_o),
    .out_addr_o (out_addr_o)
  );

  fir_fold_sched #(.TAPS(3), .N_IN(8), .ADDR_W(8), .SEL_W(3), .MAC_LAT(1)) dut_s (
    .clk100_i   (clk100_i),
    .reset_i    (reset_s),
    .start_i    (start_s),
`ifdef FIR_SCHED_ABORT_EN
    .abort_i    (abort_s),
`endif
    .busy_o     (busy_s),
    .done_o     (done_s),
    .in_rd_en_o (rd_s),
    .in_addr_o  (addr_s),
    .coef_sel_o (sel_s),
    .acc_ld_o   (ld_s),
    .acc_en_o   (en_s),
    .out_wr_en_o(wr_s),
    .out_addr_o (oaddr_s)
  );

  always #5 clk100_i = ~clk100_i;

  task automatic tick();
    @(posedge clk100_i);
    #1;
  endtask

  // Expected outputs c cycles after the edge that accepted start (c<0: idle).
  // Packing: {busy, done, rd_en, in_addr[8], coef_sel[3], acc_ld, acc_en, wr_en, out_addr[8]}
  function automatic logic [24:0] model(int c, int taps, int nin, int lat);
    int ni, done_c, m;
    logic b, d, rd, ld, en, wr;
    logic [7:0] a, oa;
    logic [2:0] cs;
    ni = (nin - taps + 1) * taps;
    done_c = ni + lat + 1;
    b = 0; d = 0; rd = 0; ld = 0; en = 0; wr = 0; a = 0; oa = 0; cs = 0;
    if (c >= 0 && c <= done_c) b = 1;
    if (c == done_c) d = 1;
    if (c >= 0 && c < ni) begin
      rd = 1;
      a  = 8'(c / taps + taps - 1 - c % taps);
      cs = 3'(c % taps);
    end
    m = c - lat;
    if (m >= 0 && m < ni) begin
      ld = (m % taps == 0);
      en = !ld;
    end
    m = c - lat - 1;
    if (m >= 0 && m < ni && (m % taps == taps - 1)) begin
      wr = 1;
      oa = 8'(m / taps);
    end
    return {b, d, rd, a, cs, ld, en, wr, oa};
  endfunction

  function automatic logic [24:0] act_d();
    return {busy_o, done_o, in_rd_en_o, in_addr_o, coef_sel_o,
            acc_ld_o, acc_en_o, out_wr_en_o, out_addr_o};
  endfunction

  task automatic test_reset();
    reset_i = 0; reset_s = 0; start_i = 1; start_s = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (act_d() !== 25'd0) begin
        n_fail++;
        $display("FAIL reset_state c=%0d got=%h exp=%h", c, act_d(), 25'd0);
      end
    end
    start_i = 0; start_s = 0; reset_i = 1; reset_s = 1;
    tick();
    n_checks++;
    if ({busy_s, done_s, rd_s, ld_s, en_s, wr_s} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_state_small got=%b exp=%b", {busy_s, done_s, rd_s, ld_s, en_s, wr_s}, 6'd0);
    end
  endtask

  task automatic test_default_pass();
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, first_wr = -1, done_at = -1, exp_oa = 0, order_bad = 0;
    logic [24:0] exp;
    start_i = 1;
    tick();
    start_i = 0;
    for (int c = 0; c < D_DONE + 4; c++) begin
      exp = model(c, D_TAPS, D_NIN, D_LAT);
      n_checks++;
      if (act_d() !== exp) begin
        n_fail++;
        $display("FAIL default_pass c=%0d got=%h exp=%h", c, act_d(), exp);
      end
      if (in_rd_en_o) rd_cnt++;
      if (out_wr_en_o) begin
        if (first_wr < 0) first_wr = c;
        if (out_addr_o != 8'(exp_oa)) order_bad++;
        exp_oa++;
        wr_cnt++;
      end
      if (done_o) begin
        done_cnt++;
        done_at = c;
      end
      tick();
    end
    n_checks++;
    if (rd_cnt !== 1260) begin n_fail++; $display("FAIL rd_count got=%0d exp=%0d", rd_cnt, 1260); end
    n_checks++;
    if (wr_cnt !== 252) begin n_fail++; $display("FAIL wr_count got=%0d exp=%0d", wr_cnt, 252); end
    n_checks++;
    if (first_wr !== 7) begin n_fail++; $display("FAIL first_write got=%0d exp=%0d", first_wr, 7); end
    n_checks++;
    if (order_bad !== 0) begin n_fail++; $display("FAIL out_addr_order got=%0d bad exp=0", order_bad); end
    n_checks++;
    if (done_cnt !== 1 || done_at !== 1263) begin
      n_fail++;
      $display("FAIL done_pulse got=%0d@%0d exp=1@1263", done_cnt, done_at);
    end
  endtask

  task automatic test_first_outputs();
    logic [7:0] exp_addr [10];
    logic [7:0] a;
    exp_addr = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    start_i = 1;
    tick();
    start_i = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        a = exp_addr[c];
        n_checks++;
        if (in_addr_o !== a || coef_sel_o !== 3'(c % 5) || in_rd_en_o !== 1'b1) begin
          n_fail++;
          $display("FAIL first_issue c=%0d got=%0d/%0d exp=%0d/%0d", c, in_addr_o, coef_sel_o, a, c % 5);
        end
      end
      if (c >= 2) begin
        n_checks++;
        if (acc_ld_o !== (c == 2 || c == 7)) begin
          n_fail++;
          $display("FAIL first_acc_ld c=%0d got=%b exp=%b", c, acc_ld_o, (c == 2 || c == 7));
        end
      end
      tick();
    end
    reset_i = 0;
    tick();
    reset_i = 1;
    tick();
    n_checks++;
    if (act_d() !== 25'd0) begin
      n_fail++;
      $display("FAIL first_outputs_idle got=%h exp=%h", act_d(), 25'd0);
    end
  endtask

  task automatic test_start_held();
    int done_cnt = 0, wr_cnt = 0;
    logic [24:0] exp;
    start_i = 1;
    tick();
    for (int c = 0; c < D_DONE + 4; c++) begin
      start_i = (c < 19) || (c == 599) || (c < 40 && $urandom_range(0, 1) == 1);
      exp = model(c, D_TAPS, D_NIN, D_LAT);
      n_checks++;
      if (act_d() !== exp) begin
        n_fail++;
        $display("FAIL start_held c=%0d got=%h exp=%h", c, act_d(), exp);
      end
      if (done_o) done_cnt++;
      if (out_wr_en_o) wr_cnt++;
      tick();
    end
    start_i = 0;
    n_checks++;
    if (done_cnt !== 1 || wr_cnt !== 252) begin
      n_fail++;
      $display("FAIL start_held_single_pass got=%0d done %0d wr exp=1 done 252 wr", done_cnt, wr_cnt);
    end
  endtask

  task automatic test_reset_mid_pass();
    int late_wr = 0;
    logic [24:0] exp;
    start_i = 1;
    tick();
    start_i = 0;
    for (int c = 0; c < 330; c++) begin
      if (c == 299) reset_i = 0;
      if (c == 300) reset_i = 1;
      exp = (c < 300) ? model(c, D_TAPS, D_NIN, D_LAT) : 25'd0;
      n_checks++;
      if (act_d() !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_pass c=%0d got=%h exp=%h", c, act_d(), exp);
      end
      if (c >= 300 && out_wr_en_o) late_wr++;
      tick();
    end
    n_checks++;
    if (late_wr !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_pass_writes got=%0d exp=0", late_wr);
    end
    test_default_pass();
  endtask

  task automatic test_small_params();
    int wr_cnt = 0, first_wr = -1, last_oa = -1;
    logic [24:0] exp, act;
    start_s = 1;
    tick();
    start_s = 0;
    for (int c = 0; c < 24; c++) begin
      act = {busy_s, done_s, rd_s, addr_s, sel_s, ld_s, en_s, wr_s, oaddr_s};
      exp = model(c, 3, 8, 1);
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL small_params c=%0d got=%h exp=%h", c, act, exp);
      end
      if (c < 3) begin
        n_checks++;
        if (addr_s !== 8'(2 - c)) begin
          n_fail++;
          $display("FAIL small_in_addr c=%0d got=%0d exp=%0d", c, addr_s, 2 - c);
        end
      end
      if (wr_s) begin
        if (first_wr < 0) first_wr = c;
        last_oa = int'(oaddr_s);
        wr_cnt++;
      end
      tick();
    end
    n_checks++;
    if (wr_cnt !== 6 || first_wr !== 4 || last_oa !== 5) begin
      n_fail++;
      $display("FAIL small_writes got=%0d wr first@%0d last=%0d exp=6 wr first@4 last=5", wr_cnt, first_wr, last_oa);
    end
  endtask

`ifdef FIR_SCHED_ABORT_EN
  task automatic test_abort();
    logic [24:0] exp;
    start_i = 1;
    tick();
    start_i = 0;
    for (int c = 0; c < 110; c++) begin
      abort_i = (c == 99);
      exp = (c < 100) ? model(c, D_TAPS, D_NIN, D_LAT) : 25'd0;
      n_checks++;
      if (act_d() !== exp) begin
        n_fail++;
        $display("FAIL abort c=%0d got=%h exp=%h", c, act_d(), exp);
      end
      tick();
    end
    abort_i = 0;
    test_default_pass();
  endtask
`endif

  initial begin
    test_reset();
    test_default_pass();
    test_first_outputs();
    test_start_held();
    test_reset_mid_pass();
    test_small_params();
`ifdef FIR_SCHED_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
